flex_bit_timer: RTL
===================

FLEX_BIT_TIMER -- requirements
Module: flex_bit_timer

Interface
REQ-001 SHALL have parameter CNT_BITS, default 8, meaning width of the per-bit clock counter and of clks_per_bit.
REQ-002 SHALL have parameter NUM_BITS, default 9, meaning bit periods per packet (range 1..255).
REQ-003 SHALL have parameter IDX_BITS, default $clog2(NUM_BITS+1), meaning width of bit_index.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  pulse that begins a packet.
REQ-007 SHALL have port abort  input  1  pulse that terminates a packet.
REQ-008 SHALL have port enable_timer  input  1  count enable; low pauses a running packet.
REQ-009 SHALL have port clks_per_bit  input  CNT_BITS  clock cycles per bit period.
REQ-010 SHALL have port sample_strobe  output  1  one-cycle mid-bit pulse.
REQ-011 SHALL have port shift_strobe  output  1  one-cycle end-of-bit pulse.
REQ-012 SHALL have port packet_done  output  1  one-cycle end-of-packet pulse.
REQ-013 SHALL have port busy  output  1  high while in RUN.
REQ-014 SHALL have port bit_index  output  IDX_BITS  index of the bit period in progress (0-based).

Function
REQ-015 SHALL implement FSM states IDLE and RUN.
REQ-016 IDLE: start=1 and abort=0 at an edge -> RUN; clk_cnt=1, bit_cnt=0, div latched from clks_per_bit.
REQ-017 div latch SHALL clamp: clks_per_bit<2 latched as 2; clks_per_bit changes during RUN ignored.
REQ-018 RUN, enable_timer=1: clk_cnt increments each edge; at clk_cnt==div it wraps to 1 and bit_cnt increments.
REQ-019 RUN, enable_timer=0: clk_cnt, bit_cnt and state hold; all strobes 0.
REQ-020 sample_strobe SHALL be 1 when RUN, enable_timer=1 and clk_cnt==div>>1.
REQ-021 shift_strobe SHALL be 1 when RUN, enable_timer=1 and clk_cnt==div.
REQ-022 packet_done SHALL be 1 when shift_strobe=1 and bit_cnt==NUM_BITS-1; next state IDLE, counters 0.
REQ-023 Latency: first shift_strobe in the div-th cycle after the start-sampling edge; packet_done in cycle NUM_BITS*div.
REQ-024 Back-to-back: start=1 in the packet_done cycle SHALL re-enter RUN with clk_cnt=1, bit_cnt=0, no idle gap.
REQ-025 start while RUN (other than REQ-024) SHALL be ignored.
REQ-026 abort=1 at any edge SHALL force IDLE, counters 0, with no packet_done; abort wins over simultaneous start.
REQ-027 bit_index SHALL equal bit_cnt in RUN and 0 in IDLE; busy = (state==RUN).
REQ-028 Strobe outputs SHALL be pure decodes of registered state and enable_timer; no other combinational input-to-output path.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, clk_cnt=0, bit_cnt=0, div=2; rst overrides start/abort.
REQ-030 While rst is high and on the first cycle after release: busy=0, bit_index=0, all strobes=0.
REQ-031 rst asserted mid-packet SHALL abandon the packet without packet_done.

Structure
REQ-032 Package flex_bit_timer_pkg SHALL hold the state enum typedef (IDLE, RUN) and constant MIN_DIV=2.
REQ-033 One sub-module, sync_flex_counter (parametrised width, synchronous active-high rst, clear, count_enable, rollover_val, rollover_flag), SHALL be instantiated twice: clock counter and bit counter.

Verification
REQ-034 Defaults, clks_per_bit=10, start pulse, enable_timer=1 -> shift_strobe in cycles 10,20..90, sample_strobe in cycles 5,15..85, packet_done in cycle 90, busy low from cycle 91.
REQ-035 clks_per_bit=1 -> clamped to 2; shift_strobe every 2 cycles, packet_done in cycle 18.
REQ-036 enable_timer low for cycles 12..16 (5 cycles) of a div=10 packet -> second shift_strobe moves from cycle 20 to 25, packet_done to cycle 95.
REQ-037 abort in cycle 33 with start also high -> IDLE next cycle, bit_index=0, no packet_done, no restart.
REQ-038 start held in the packet_done cycle (90) -> busy stays 1, next shift_strobe in cycle 100, packet_done in cycle 180.
REQ-039 rst pulsed in cycle 47 mid-packet -> all outputs 0 from the next cycle, no packet_done; a new start then runs a full 90-cycle packet.

Source files
------------

// File: rtl/flex_bit_timer_pkg.sv
// -----------------------------------------------------------------------------
// flex_bit_timer_pkg
//   Shared definitions for the flexible bit timer:
//     state_t  - controller state encoding (IDLE, RUN)
//     MIN_DIV  - smallest usable clocks-per-bit divider; smaller requests are
//                raised to this so that a mid-bit sample point always exists
//                before the end-of-bit point.
// -----------------------------------------------------------------------------
package flex_bit_timer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_DIV = 2;

endpackage : flex_bit_timer_pkg

// File: rtl/flex_bit_timer_counter.sv
// -----------------------------------------------------------------------------
// sync_flex_counter
//   Up-counter with programmable rollover. Counts 0 -> 1 -> ... ->
//   rollover_val -> 1 -> ...; the value 0 is only reached through reset or
//   clear, so after a clear the first enabled edge lands on 1.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset (count -> 0)
//   clear         in   synchronous clear (count -> 0), wins over count_enable
//   count_enable  in   advance the count on this edge
//   rollover_val  in   WIDTH  value after which the count wraps back to 1
//   count_out     out  WIDTH  registered count
//   rollover_flag out  high while count_out == rollover_val
// -----------------------------------------------------------------------------
module sync_flex_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_roll;

  assign at_roll = (count_q == rollover_val);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (at_roll) begin
        count_d = WIDTH'(1);
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = at_roll;

endmodule : sync_flex_counter

// File: rtl/flex_bit_timer.sv
// -----------------------------------------------------------------------------
// flex_bit_timer
//   Bit-period timer for serial framing. After a start pulse it produces
//   NUM_BITS bit periods of div clocks each, where div is clks_per_bit
//   captured (and raised to MIN_DIV) when the packet begins. Each bit period
//   gives a mid-bit sample_strobe and an end-of-bit shift_strobe; the last
//   shift_strobe is accompanied by packet_done. enable_timer low freezes a
//   running packet.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no packet; counters held at 0, waiting for start
//   RUN   | packet in progress; clk_cnt walks 1..div, bit_cnt 0..NUM_BITS-1
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   start          in   begin a packet (ignored mid-packet except on the
//                       packet_done cycle, where it chains a new packet)
//   abort          in   drop the current packet, no packet_done; beats start
//   enable_timer   in   count enable; low pauses a running packet
//   clks_per_bit   in   CNT_BITS  clocks per bit period, sampled at start
//   sample_strobe  out  mid-bit pulse
//   shift_strobe   out  end-of-bit pulse
//   packet_done    out  end-of-packet pulse
//   busy           out  high in RUN
//   bit_index      out  IDX_BITS  bit period in progress, 0 when idle
// -----------------------------------------------------------------------------
module flex_bit_timer
  import flex_bit_timer_pkg::*;
#(
  parameter int CNT_BITS = 8,
  parameter int NUM_BITS = 9,
  parameter int IDX_BITS = $clog2(NUM_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                enable_timer,
  input  logic [CNT_BITS-1:0] clks_per_bit,
  output logic                sample_strobe,
  output logic                shift_strobe,
  output logic                packet_done,
  output logic                busy,
  output logic [IDX_BITS-1:0] bit_index
);

  localparam logic [CNT_BITS-1:0] DIV_FLOOR = CNT_BITS'(MIN_DIV);
  localparam logic [IDX_BITS-1:0] LAST_BIT  = IDX_BITS'(NUM_BITS - 1);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] div_q, div_d;

  logic [CNT_BITS-1:0] clk_cnt;
  logic                clk_at_div;
  logic                clk_clear, clk_en;

  logic [IDX_BITS-1:0] bit_cnt;
  logic                bit_is_last;
  logic                bit_clear, bit_en;

  logic                run_active;
  logic                go;
  logic [CNT_BITS-1:0] div_in;

  // Divider value that would be captured if a packet started this cycle.
  assign div_in = (clks_per_bit < DIV_FLOOR) ? DIV_FLOOR : clks_per_bit;
  assign go     = start & ~abort;

  sync_flex_counter #(
    .WIDTH (CNT_BITS)
  ) u_clk_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (clk_clear),
    .count_enable  (clk_en),
    .rollover_val  (div_q),
    .count_out     (clk_cnt),
    .rollover_flag (clk_at_div)
  );

  // The bit counter never actually rolls over: it is cleared on the last
  // shift. Its rollover flag is used purely as the "last bit" decode.
  sync_flex_counter #(
    .WIDTH (IDX_BITS)
  ) u_bit_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (bit_clear),
    .count_enable  (bit_en),
    .rollover_val  (LAST_BIT),
    .count_out     (bit_cnt),
    .rollover_flag (bit_is_last)
  );

  // Strobes decode registered state plus enable_timer only.
  assign run_active    = (state_q == RUN) & enable_timer;
  assign sample_strobe = run_active & (clk_cnt == (div_q >> 1));
  assign shift_strobe  = run_active & clk_at_div;
  assign packet_done   = shift_strobe & bit_is_last;

  assign busy      = (state_q == RUN);
  assign bit_index = (state_q == RUN) ? bit_cnt : '0;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    clk_clear = 1'b0;
    clk_en    = 1'b0;
    bit_clear = 1'b0;
    bit_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_clear = 1'b1;
        bit_clear = 1'b1;
        if (go) begin
          // Counter sits at 0 in IDLE, so one enabled edge lands it on 1.
          state_d   = RUN;
          div_d     = div_in;
          clk_clear = 1'b0;
          clk_en    = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          clk_clear = 1'b1;
          bit_clear = 1'b1;
        end else if (enable_timer) begin
          clk_en = 1'b1;
          if (clk_at_div) begin
            if (bit_is_last) begin
              bit_clear = 1'b1;
              if (start) begin
                // Chained packet: clk_cnt wraps div -> 1 by itself, so only
                // the bit counter needs restarting and div is re-captured.
                div_d = div_in;
              end else begin
                state_d   = IDLE;
                clk_clear = 1'b1;
              end
            end else begin
              bit_en = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d   = IDLE;
        clk_clear = 1'b1;
        bit_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= DIV_FLOOR;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

endmodule : flex_bit_timer
